alu_issue_stage: RTL and testbench

//   ID/EX pipeline stage that produces the ALU's operator/operand_a/operand_b inputs.

---
 rtl/alu_issue_stage.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the ALU.
// It resolves the source operands from the register file, from forwarding paths, from the
// immediate or from the PC. It detects load-use hazards and registers the result for EX.

package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_e;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      id_valid_i,
    output logic                      id_ready_o,
    input  alu_opcode_e               id_operator_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
    input  logic                      id_rd_we_i,
    input  logic                      id_is_load_i,
    input  logic                      id_use_imm_i,
    input  logic                      id_use_pc_i,
    input  logic [DATA_WIDTH-1:0]     id_imm_i,
    input  logic [DATA_WIDTH-1:0]     id_pc_i,
    input  logic [DATA_WIDTH-1:0]     rf_rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rf_rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     ex_result_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic                      mem_rd_we_i,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
    input  logic                      wb_rd_we_i,
    input  logic [DATA_WIDTH-1:0]     wb_rd_data_i,
    input  logic                      ex_ready_i,
    output logic                      ex_valid_o,
    output alu_opcode_e               ex_operator_o,
    output logic [DATA_WIDTH-1:0]     ex_operand_a_o,
    output logic [DATA_WIDTH-1:0]     ex_operand_b_o,
    output logic [DATA_WIDTH-1:0]     ex_store_data_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
    output logic                      ex_rd_we_o,
    output logic                      ex_is_load_o
);

    logic                      ex_valid_q,  ex_valid_d;
    alu_opcode_e               operator_q,  operator_d;
    logic [DATA_WIDTH-1:0]     operand_a_q, operand_a_d;
    logic [DATA_WIDTH-1:0]     operand_b_q, operand_b_d;
    logic [DATA_WIDTH-1:0]     store_q,     store_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
    logic                      rd_we_q,     rd_we_d;
    logic                      is_load_q,   is_load_d;

    logic                      ex_fwd_en_s;
    logic                      load_use_s;
    logic                      id_ready_s;
    logic [DATA_WIDTH-1:0]     fwd_rs1_s;
    logic [DATA_WIDTH-1:0]     fwd_rs2_s;

    // Newest producer wins: EX, then MEM, then WB, then the register file. x0 is hardwired to zero.
    function automatic logic [DATA_WIDTH-1:0] resolve_src(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     rf_data,
        input logic                      ex_en,
        input logic [REG_ADDR_WIDTH-1:0] ex_rd,
        input logic [DATA_WIDTH-1:0]     ex_data,
        input logic                      mem_we,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd,
        input logic [DATA_WIDTH-1:0]     mem_data,
        input logic                      wb_we,
        input logic [REG_ADDR_WIDTH-1:0] wb_rd,
        input logic [DATA_WIDTH-1:0]     wb_data
    );
        logic [DATA_WIDTH-1:0] val;
        if (rs == {REG_ADDR_WIDTH{1'b0}}) begin
            val = {DATA_WIDTH{1'b0}};
        end else if (ex_en && (ex_rd == rs)) begin
            val = ex_data;
        end else if (mem_we && (mem_rd == rs)) begin
            val = mem_data;
        end else if (wb_we && (wb_rd == rs)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Operand resolution, load-use detection and the handshake back to the decoder.
    always_comb begin
        // A load result only exists after MEM, so a load in EX is never a forwarding source.
        ex_fwd_en_s = ex_valid_q && rd_we_q && !is_load_q;
        fwd_rs1_s   = resolve_src(id_rs1_addr_i, rf_rs1_data_i, ex_fwd_en_s, rd_addr_q, ex_result_i,
                                  mem_rd_we_i, mem_rd_addr_i, mem_rd_data_i,
                                  wb_rd_we_i, wb_rd_addr_i, wb_rd_data_i);
        fwd_rs2_s   = resolve_src(id_rs2_addr_i, rf_rs2_data_i, ex_fwd_en_s, rd_addr_q, ex_result_i,
                                  mem_rd_we_i, mem_rd_addr_i, mem_rd_data_i,
                                  wb_rd_we_i, wb_rd_addr_i, wb_rd_data_i);
        load_use_s  = ex_valid_q && is_load_q && rd_we_q && (rd_addr_q != {REG_ADDR_WIDTH{1'b0}}) &&
                      ((rd_addr_q == id_rs1_addr_i) ||
                       ((rd_addr_q == id_rs2_addr_i) && !id_use_imm_i));
        id_ready_s  = !flush_i && (!ex_valid_q || ex_ready_i) && !load_use_s;
    end

    // Next-state selection for the EX register: flush, hold, capture or bubble.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        operator_d  = operator_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        store_d     = store_q;
        rd_addr_d   = rd_addr_q;
        rd_we_d     = rd_we_q;
        is_load_d   = is_load_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (ex_valid_q && !ex_ready_i) begin
            ex_valid_d = 1'b1;
        end else if (id_valid_i && id_ready_s) begin
            ex_valid_d  = 1'b1;
            operator_d  = id_operator_i;
            operand_a_d = id_use_pc_i  ? id_pc_i  : fwd_rs1_s;
            operand_b_d = id_use_imm_i ? id_imm_i : fwd_rs2_s;
            store_d     = fwd_rs2_s;
            rd_addr_d   = id_rd_addr_i;
            rd_we_d     = id_rd_we_i;
            is_load_d   = id_is_load_i;
        end else begin
            ex_valid_d = 1'b0;
            rd_we_d    = 1'b0;
        end
    end

    // EX pipeline register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q  <= 1'b0;
            operator_q  <= ALU_ADD;
            operand_a_q <= {DATA_WIDTH{1'b0}};
            operand_b_q <= {DATA_WIDTH{1'b0}};
            store_q     <= {DATA_WIDTH{1'b0}};
            rd_addr_q   <= {REG_ADDR_WIDTH{1'b0}};
            rd_we_q     <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            operator_q  <= operator_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            store_q     <= store_d;
            rd_addr_q   <= rd_addr_d;
            rd_we_q     <= rd_we_d;
            is_load_q   <= is_load_d;
        end
    end

    assign id_ready_o      = id_ready_s;
    assign ex_valid_o      = ex_valid_q;
    assign ex_operator_o   = operator_q;
    assign ex_operand_a_o  = operand_a_q;
    assign ex_operand_b_o  = operand_b_q;
    assign ex_store_data_o = store_q;
    assign ex_rd_addr_o    = rd_addr_q;
    assign ex_rd_we_o      = rd_we_q;
    assign ex_is_load_o    = is_load_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage, driven by directed vectors.
// Each vector has a hand-computed expected EX payload.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, id_valid_i, id_ready_o;
    alu_opcode_e id_operator_i, ex_operator_o;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic        id_rd_we_i, id_is_load_i, id_use_imm_i, id_use_pc_i;
    logic [31:0] id_imm_i, id_pc_i, rf_rs1_data_i, rf_rs2_data_i, ex_result_i;
    logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
    logic        mem_rd_we_i, wb_rd_we_i;
    logic [31:0] mem_rd_data_i, wb_rd_data_i;
    logic        ex_ready_i, ex_valid_o;
    logic [31:0] ex_operand_a_o, ex_operand_b_o, ex_store_data_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_rd_we_o, ex_is_load_o;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   waits;

    alu_issue_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_operator_i(id_operator_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_rd_we_i(id_rd_we_i), .id_is_load_i(id_is_load_i), .id_use_imm_i(id_use_imm_i),
        .id_use_pc_i(id_use_pc_i), .id_imm_i(id_imm_i), .id_pc_i(id_pc_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i), .ex_result_i(ex_result_i),
        .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_we_i(mem_rd_we_i), .mem_rd_data_i(mem_rd_data_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_we_i(wb_rd_we_i), .wb_rd_data_i(wb_rd_data_i),
        .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o), .ex_operator_o(ex_operator_o),
        .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o),
        .ex_store_data_o(ex_store_data_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_rd_we_o(ex_rd_we_o), .ex_is_load_o(ex_is_load_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sd, input logic [4:0] rd, input logic we, input logic ld);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.sd = sd; e.rd = rd; e.we = we; e.ld = ld;
        exp_q.push_back(e);
    endtask

    task automatic set_id(input alu_opcode_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic ld, input logic use_imm,
                          input logic use_pc, input logic [31:0] imm, input logic [31:0] pc);
        id_operator_i = op;  id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
        id_rd_we_i    = we;  id_is_load_i  = ld;  id_use_imm_i  = use_imm;
        id_use_pc_i   = use_pc; id_imm_i = imm; id_pc_i = pc;
        id_valid_i    = 1'b1;
    endtask

    // Returns at posedge+1 after acceptance; counts cycles spent with id_ready_o low.
    task automatic wait_accept(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (id_ready_o) begin
                @(posedge clk_i); #1;
                id_valid_i = 1'b0;
                return;
            end
            n++;
            @(posedge clk_i); #1;
        end
        total++; bad++;
        $display("FAIL accept_timeout: got no acceptance in 20 cycles, expected acceptance");
        id_valid_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},    {63'd0, ex_valid_o},     64'd0);
        check({tag, "_operator"}, {60'd0, ex_operator_o},  {60'd0, ALU_ADD});
        check({tag, "_opa"},      {32'd0, ex_operand_a_o}, 64'd0);
        check({tag, "_opb"},      {32'd0, ex_operand_b_o}, 64'd0);
        check({tag, "_store"},    {32'd0, ex_store_data_o}, 64'd0);
        check({tag, "_rd"},       {59'd0, ex_rd_addr_o},   64'd0);
        check({tag, "_rd_we"},    {63'd0, ex_rd_we_o},     64'd0);
        check({tag, "_is_load"},  {63'd0, ex_is_load_o},   64'd0);
        check({tag, "_id_ready"}, {63'd0, id_ready_o},     64'd1);
    endtask

    // Monitor: every instruction leaving EX is compared against the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && ex_valid_o && ex_ready_i) begin
            exp_t act;
            act = {ex_operator_o, ex_operand_a_o, ex_operand_b_o, ex_store_data_o,
                   ex_rd_addr_o, ex_rd_we_o, ex_is_load_o};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL ex_unexpected: got op=%0d a=0x%0h b=0x%0h rd=%0d, expected no instruction",
                         act.op, act.a, act.b, act.rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL ex_payload: got op=%0d a=0x%0h b=0x%0h sd=0x%0h rd=%0d we=%0b ld=%0b expected op=%0d a=0x%0h b=0x%0h sd=0x%0h rd=%0d we=%0b ld=%0b",
                             act.op, act.a, act.b, act.sd, act.rd, act.we, act.ld,
                             e.op, e.a, e.b, e.sd, e.rd, e.we, e.ld);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
        id_operator_i = ALU_ADD; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rd_addr_i = 5'd0;
        id_rd_we_i = 1'b0; id_is_load_i = 1'b0; id_use_imm_i = 1'b0; id_use_pc_i = 1'b0;
        id_imm_i = 32'd0; id_pc_i = 32'd0; rf_rs1_data_i = 32'd0; rf_rs2_data_i = 32'd0;
        ex_result_i = 32'd0; mem_rd_addr_i = 5'd0; mem_rd_we_i = 1'b0; mem_rd_data_i = 32'd0;
        wb_rd_addr_i = 5'd0; wb_rd_we_i = 1'b0; wb_rd_data_i = 32'd0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_state("rst");
        @(posedge clk_i); #1;

        // addi x1,x0,5 with garbage in the register file
        rf_rs1_data_i = 32'hBAD0_BAD0; rf_rs2_data_i = 32'h1234_5678;
        set_id(ALU_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        push(ALU_ADD, 32'd0, 32'd5, 32'd0, 5'd1, 1'b1, 1'b0);
        wait_accept(waits);
        check("addi_wait", waits, 64'd0);

        // plain register-file operands
        rf_rs1_data_i = 32'h100; rf_rs2_data_i = 32'h200;
        set_id(ALU_ADD, 5'd5, 5'd6, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push(ALU_ADD, 32'h100, 32'h200, 32'h200, 5'd3, 1'b1, 1'b0);
        wait_accept(waits);

        // EX beats MEM for rs1; WB beats RF for rs2
        ex_result_i = 32'h10;
        mem_rd_addr_i = 5'd3; mem_rd_we_i = 1'b1; mem_rd_data_i = 32'h20;
        wb_rd_addr_i  = 5'd7; wb_rd_we_i  = 1'b1; wb_rd_data_i  = 32'h77;
        rf_rs1_data_i = 32'hAAAA; rf_rs2_data_i = 32'hBBBB;
        set_id(ALU_SUB, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push(ALU_SUB, 32'h10, 32'h77, 32'h77, 5'd8, 1'b1, 1'b0);
        wait_accept(waits);
        mem_rd_we_i = 1'b0; wb_rd_we_i = 1'b0;

        // PC and immediate operands; store data still forwarded from EX
        ex_result_i = 32'h55;
        set_id(ALU_ADD, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h400);
        push(ALU_ADD, 32'h400, 32'hFFFF_FFFC, 32'h55, 5'd9, 1'b1, 1'b0);
        wait_accept(waits);

        // load x4, then a dependent add: one bubble, load data from MEM
        rf_rs1_data_i = 32'h1000;
        set_id(ALU_ADD, 5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'd8, 32'd0);
        push(ALU_ADD, 32'h1000, 32'd8, 32'd0, 5'd4, 1'b1, 1'b1);
        wait_accept(waits);
        rf_rs1_data_i = 32'h11; rf_rs2_data_i = 32'h9999;
        mem_rd_addr_i = 5'd4; mem_rd_we_i = 1'b1; mem_rd_data_i = 32'hDEAD;
        set_id(ALU_ADD, 5'd11, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push(ALU_ADD, 32'h11, 32'hDEAD, 32'hDEAD, 5'd10, 1'b1, 1'b0);
        wait_accept(waits);
        check("load_use_bubbles", waits, 64'd1);
        mem_rd_we_i = 1'b0;

        // EX back-pressure for three cycles
        set_id(ALU_OR, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33, 32'd0);
        push(ALU_OR, 32'd0, 32'h33, 32'd0, 5'd12, 1'b1, 1'b0);
        wait_accept(waits);
        ex_ready_i = 1'b0;
        ex_result_i = 32'h66; rf_rs1_data_i = 32'h5A5A; rf_rs2_data_i = 32'h1313;
        set_id(ALU_XOR, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push(ALU_XOR, 32'h66, 32'h1313, 32'h1313, 5'd14, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_valid", {63'd0, ex_valid_o}, 64'd1);
            check("stall_opb", {32'd0, ex_operand_b_o}, 64'h33);
            check("stall_rd", {59'd0, ex_rd_addr_o}, 64'd12);
            check("stall_id_ready", {63'd0, id_ready_o}, 64'd0);
            @(posedge clk_i); #1;
        end
        ex_ready_i = 1'b1;
        wait_accept(waits);
        check("stall_release_wait", waits, 64'd0);

        // flush together with a valid decoder instruction
        set_id(ALU_AND, 5'd1, 5'd2, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_id_ready", {63'd0, id_ready_o}, 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; id_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_ex_valid", {63'd0, ex_valid_o}, 64'd0);
        @(posedge clk_i); #1;

        // reset while stalled discards the held instruction
        set_id(ALU_ADD, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 32'h77, 32'd0);
        wait_accept(waits);
        ex_ready_i = 1'b0;
        @(negedge clk_i);
        check("pre_rst_valid", {63'd0, ex_valid_o}, 64'd1);
        check("pre_rst_opb", {32'd0, ex_operand_b_o}, 64'h77);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_state("stall_rst");
        @(posedge clk_i); #1;
        ex_ready_i = 1'b1;

        // x0 is never forwarded, even from a MEM write to x0
        rf_rs1_data_i = 32'hABC; rf_rs2_data_i = 32'hDEF;
        mem_rd_addr_i = 5'd0; mem_rd_we_i = 1'b1; mem_rd_data_i = 32'hFFFF;
        set_id(ALU_AND, 5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push(ALU_AND, 32'd0, 32'd0, 32'd0, 5'd16, 1'b1, 1'b0);
        wait_accept(waits);

        // MEM beats WB; unmatched rs2 comes from the register file
        ex_result_i = 32'h4444;
        mem_rd_addr_i = 5'd20; mem_rd_data_i = 32'h2020;
        wb_rd_addr_i = 5'd20; wb_rd_we_i = 1'b1; wb_rd_data_i = 32'h3030;
        rf_rs1_data_i = 32'h1; rf_rs2_data_i = 32'h2;
        set_id(ALU_SLT, 5'd20, 5'd21, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push(ALU_SLT, 32'h2020, 32'h2, 32'h2, 5'd17, 1'b1, 1'b0);
        wait_accept(waits);
        mem_rd_we_i = 1'b0; wb_rd_we_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() != 0) begin
                @(posedge clk_i); #1;
            end
        end
        check("scoreboard_drained", exp_q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
